// File: rtl/audio_pkg.sv
// audio_pkg: tone codes, classifier/FSM enums and default half-periods shared with the generator
package audio_pkg;

    localparam logic [1:0] TONE_NONE = 2'd0;
    localparam logic [1:0] TONE_SHOT = 2'd1;
    localparam logic [1:0] TONE_COLL = 2'd2;

    localparam int DEF_SHOT_HALF = 65536;
    localparam int DEF_COLL_HALF = 524288;
    localparam int DEF_TOL       = 1024;
    localparam int DEF_SILENCE   = 1048576;

    typedef enum logic [1:0] {SHOT, COLL, OTHER} cls_t;
    typedef enum logic [1:0] {IDLE, MEASURE, LOCKED} state_t;

    // Inclusive +/- tolerance test; 32-bit operands keep the subtraction from underflowing.
    function automatic logic near(input logic [31:0] meas, input logic [31:0] nom, input logic [31:0] tol);
        return ((meas >= nom) ? meas - nom : nom - meas) <= tol;
    endfunction

endpackage

// File: rtl/audio_edge_sync.sv
// audio_edge_sync: two-flop synchronizer for the async audio line plus any-polarity edge detect
module audio_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic pin_in,
    output logic transition,
    output logic level
);

    logic sync1, sync2, prev;

    // Synchronizer chain and previous-level register for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
        end else begin
            sync1 <= pin_in;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign transition = sync2 ^ prev;
    assign level      = sync2;

endmodule

// File: rtl/audio_tone_decoder.sv
// audio_tone_decoder: measures half-periods of a 1-bit audio line and locks onto shot/collision tones
// Optional AUDIO_DEC_STATS_EN adds saturating 16-bit lock counters shot_count/coll_count.
module audio_tone_decoder
    import audio_pkg::*;
#(
    parameter int SHOT_HALF = DEF_SHOT_HALF,
    parameter int COLL_HALF = DEF_COLL_HALF,
    parameter int TOL       = DEF_TOL,
    parameter int CONFIRM   = 2,
    parameter int SILENCE   = DEF_SILENCE,
    parameter int CW        = 21
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pin_in,
    output logic       shot_det,
    output logic       coll_det,
    output logic [1:0] tone,
    output logic       active
`ifdef AUDIO_DEC_STATS_EN
    ,
    output logic [15:0] shot_count,
    output logic [15:0] coll_count
`endif
);

    localparam logic [CW-1:0] SIL = CW'(SILENCE);
    localparam logic [7:0]    CNF = 8'(CONFIRM);

    logic          transition;
    logic [CW-1:0] cnt;
    logic [CW:0]   meas;
    cls_t          cls, cand, cand_nx;
    state_t        state, state_nx;
    logic [7:0]    match, match_nx, m;
    logic [1:0]    tone_nx;
    logic          shot_nx, coll_nx;

    audio_edge_sync u_sync (
        .clk       (clk),
        .rst       (rst),
        .pin_in    (pin_in),
        .transition(transition),
        .level     ()
    );

    assign meas   = {1'b0, cnt} + 1'b1;
    assign cls    = near(32'(meas), SHOT_HALF, TOL) ? SHOT :
                    near(32'(meas), COLL_HALF, TOL) ? COLL : OTHER;
    assign active = state != IDLE;

    // Half-period counter: restarts on every edge, otherwise saturates at the silence limit
    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (transition)
            cnt <= '0;
        else if (cnt != SIL)
            cnt <= cnt + 1'b1;
    end

    // State, candidate tracking and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cand     <= OTHER;
            match    <= '0;
            tone     <= TONE_NONE;
            shot_det <= 1'b0;
            coll_det <= 1'b0;
        end else begin
            state    <= state_nx;
            cand     <= cand_nx;
            match    <= match_nx;
            tone     <= tone_nx;
            shot_det <= shot_nx;
            coll_det <= coll_nx;
        end
    end

    // Next-state logic: confirm candidates, lock, drop lock on class change or silence
    always_comb begin
        state_nx = state;
        cand_nx  = cand;
        match_nx = match;
        tone_nx  = tone;
        shot_nx  = 1'b0;
        coll_nx  = 1'b0;
        m        = (cls == OTHER) ? 8'd0 : 8'd1;
        case (state)
            IDLE: begin
                if (transition) begin
                    state_nx = MEASURE;
                    cand_nx  = OTHER;
                    match_nx = '0;
                end
            end
            MEASURE: begin
                if (transition) begin
                    m        = (cls == cand && cand != OTHER) ? match + 1'b1 : m;
                    cand_nx  = cls;
                    match_nx = m;
                    if (cls != OTHER && m >= CNF) begin
                        state_nx = LOCKED;
                        tone_nx  = (cls == SHOT) ? TONE_SHOT : TONE_COLL;
                        shot_nx  = cls == SHOT;
                        coll_nx  = cls == COLL;
                    end
                end
            end
            LOCKED: begin
                if (transition && cls != cand) begin
                    state_nx = MEASURE;
                    cand_nx  = cls;
                    match_nx = m;
                    tone_nx  = TONE_NONE;
                end
            end
            default: state_nx = IDLE;
        endcase
        if (state != IDLE && !transition && cnt == SIL) begin
            state_nx = IDLE;
            tone_nx  = TONE_NONE;
        end
    end

`ifdef AUDIO_DEC_STATS_EN
    // Saturating lock counters
    always_ff @(posedge clk) begin
        if (rst) begin
            shot_count <= '0;
            coll_count <= '0;
        end else begin
            if (shot_det && shot_count != 16'hFFFF)
                shot_count <= shot_count + 1'b1;
            if (coll_det && coll_count != 16'hFFFF)
                coll_count <= coll_count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_audio_tone_decoder.sv
// tb_audio_tone_decoder: directed table plus hand sequences for lock timing, switching, silence and reset
module tb_audio_tone_decoder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pin_in = 1'b0;
    logic       shot_det, coll_det, active;
    logic [1:0] tone;
`ifdef AUDIO_DEC_STATS_EN
    logic [15:0] shot_count, coll_count;
`endif

    int checks = 0;
    int errors = 0;
    int shot_seen = 0;
    int coll_seen = 0;

    typedef struct {
        int h;
        int n;
        int shots;
        int colls;
        int tone;
        int act;
    } vec_t;

    vec_t v[10];

    audio_tone_decoder #(
        .SHOT_HALF(16),
        .COLL_HALF(128),
        .TOL(2),
        .CONFIRM(2),
        .SILENCE(512),
        .CW(21)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .pin_in  (pin_in),
        .shot_det(shot_det),
        .coll_det(coll_det),
        .tone    (tone),
        .active  (active)
`ifdef AUDIO_DEC_STATS_EN
        ,
        .shot_count(shot_count),
        .coll_count(coll_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (shot_det) shot_seen++;
        if (coll_det) coll_seen++;
        if (shot_det && coll_det) chk("both_det", 1, 0);
    endtask

    task automatic reset_dut();
        pin_in = 1'b0;
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        shot_seen = 0;
        coll_seen = 0;
    endtask

    task automatic run_tone(input int h, input int n);
        repeat (n) begin
            pin_in = ~pin_in;
            repeat (h) step();
        end
    endtask

    initial begin
        v[0] = '{16, 6, 1, 0, 1, 1};
        v[1] = '{128, 6, 0, 1, 2, 1};
        v[2] = '{18, 6, 1, 0, 1, 1};
        v[3] = '{14, 6, 1, 0, 1, 1};
        v[4] = '{19, 6, 0, 0, 0, 1};
        v[5] = '{40, 6, 0, 0, 0, 1};
        v[6] = '{126, 5, 0, 1, 2, 1};
        v[7] = '{131, 5, 0, 0, 0, 1};
        v[8] = '{16, 2, 0, 0, 0, 1};
        v[9] = '{16, 3, 1, 0, 1, 1};

        reset_dut();
        chk("rst_shot_det", int'(shot_det), 0);
        chk("rst_coll_det", int'(coll_det), 0);
        chk("rst_tone", int'(tone), 0);
        chk("rst_active", int'(active), 0);

        for (int i = 0; i < 10; i++) begin
            reset_dut();
            run_tone(v[i].h, v[i].n);
            chk($sformatf("v%0d_h%0d_shots", i, v[i].h), shot_seen, v[i].shots);
            chk($sformatf("v%0d_h%0d_colls", i, v[i].h), coll_seen, v[i].colls);
            chk($sformatf("v%0d_h%0d_tone", i, v[i].h), int'(tone), v[i].tone);
            chk($sformatf("v%0d_h%0d_active", i, v[i].h), int'(active), v[i].act);
        end

        // exact lock latency: pulse 2 cycles after the 3rd edge is sampled, one cycle wide
        reset_dut();
        run_tone(16, 2);
        pin_in = ~pin_in;
        step();
        step();
        chk("lat_early_shot", int'(shot_det), 0);
        chk("lat_early_tone", int'(tone), 0);
        step();
        chk("lat_shot_det", int'(shot_det), 1);
        chk("lat_tone", int'(tone), 1);
        step();
        chk("lat_pulse_width", int'(shot_det), 0);
        chk("lat_tone_hold", int'(tone), 1);

        // shot lock then switch to collision half-periods
        reset_dut();
        run_tone(16, 4);
        repeat (112) step();
        pin_in = ~pin_in;
        step();
        step();
        chk("sw_tone_before", int'(tone), 1);
        step();
        chk("sw_tone_drop", int'(tone), 0);
        chk("sw_active", int'(active), 1);
        repeat (125) step();
        pin_in = ~pin_in;
        repeat (3) step();
        chk("sw_coll_det", int'(coll_det), 1);
        chk("sw_tone_coll", int'(tone), 2);
        chk("sw_shots_total", shot_seen, 1);

        // silence exactly when cnt reaches 512 after the last edge
        reset_dut();
        run_tone(16, 4);
        repeat (499) step();
        chk("sil_active_before", int'(active), 1);
        chk("sil_tone_before", int'(tone), 1);
        step();
        chk("sil_active_after", int'(active), 0);
        chk("sil_tone_after", int'(tone), 0);

        // edge on the saturation cycle prevents the silence transition
        reset_dut();
        run_tone(16, 4);
        repeat (497) step();
        pin_in = ~pin_in;
        repeat (3) step();
        chk("sat_edge_active", int'(active), 1);
        step();
        chk("sat_edge_active_later", int'(active), 1);

        // reset while locked, then re-lock needs three edges
        reset_dut();
        run_tone(16, 4);
        chk("mid_locked_tone", int'(tone), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_tone", int'(tone), 0);
        chk("mid_rst_active", int'(active), 0);
        chk("mid_rst_shot", int'(shot_det), 0);
        shot_seen = 0;
        run_tone(16, 2);
        chk("relock_2edges", shot_seen, 0);
        pin_in = ~pin_in;
        repeat (3) step();
        chk("relock_3rd", int'(shot_det), 1);
        chk("relock_tone", int'(tone), 1);

`ifdef AUDIO_DEC_STATS_EN
        reset_dut();
        chk("stats_rst", int'(shot_count), 0);
        repeat (3) begin
            run_tone(40, 2);
            run_tone(16, 3);
        end
        chk("stats_shot3", int'(shot_count), 3);
        chk("stats_coll0", int'(coll_count), 0);
        force dut.shot_count = 16'hFFFF;
        step();
        release dut.shot_count;
        run_tone(40, 2);
        run_tone(16, 3);
        chk("stats_sat", int'(shot_count), 65535);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/audio_tone_decoder.md
# audio_tone_decoder

Receive-side counterpart of the game's square-wave sound generator. Samples a 1-bit audio line (generator pin looped back, or an external line), measures the half-period between transitions, and classifies the tone as the "shot" tone, the "collision" tone, or neither. Emits one-cycle detection pulses plus a steady tone code. Used for on-board self-test of the sound path and as a scoreboard source in simulation.

## Interface
Parameters:
- SHOT_HALF, 65536: nominal shot-tone half-period in clk cycles.
- COLL_HALF, 524288: nominal collision-tone half-period in clk cycles.
- TOL, 1024: accepted deviation in cycles, ± around each nominal, inclusive.
- CONFIRM, 2: consecutive matching half-periods required to lock.
- SILENCE, 1048576: cycles without an edge before declaring silence.
- CW, 21: counter width; must hold SILENCE.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- pin_in  in  1  asynchronous audio line.
- shot_det  out  1  one-cycle pulse on lock to the shot tone.
- coll_det  out  1  one-cycle pulse on lock to the collision tone.
- tone  out  2  0 none, 1 shot, 2 collision; 3 never driven.
- active  out  1  high while edges are arriving (state ≠ IDLE).

## Operation
- Two-flop synchronizer sync1→sync2, plus prev register; edge = sync2 ^ prev. Any polarity counts.
- Half counter cnt (CW bits): on edge, meas = cnt+1 and cnt←0. Otherwise cnt←cnt+1, saturating at SILENCE. A line toggling every H cycles yields meas = H.
- Classification: SHOT if |meas−SHOT_HALF| ≤ TOL; else COLL if |meas−COLL_HALF| ≤ TOL; else OTHER. Compare in CW+1 bits, no underflow.
- FSM states:
  - IDLE: tone=0, active=0. First edge → MEASURE, cand=OTHER, match=0. This measurement is discarded because its start time is unknown.
  - MEASURE: on each edge:
    - class == cand and cand ≠ OTHER: match++.
    - otherwise: cand=class, match = (class==OTHER ? 0 : 1).
    - When match reaches CONFIRM → LOCKED, tone=cand, pulse the matching *_det.
  - LOCKED: same-class edge stays. Different-class edge → MEASURE with cand=class, match=1 (0 if OTHER), tone←0.
- Silence: in any non-IDLE state, cnt == SILENCE with no edge that cycle → IDLE, tone←0.
- An edge on the cycle cnt would saturate wins; no silence transition.
- At most one of shot_det/coll_det per cycle. No pulse is emitted on re-lock to the same class without first leaving LOCKED.

## Timing
- Reset values: shot_det=0, coll_det=0, tone=0, active=0, sync1/sync2/prev=0, cnt=0, FSM=IDLE.
- Reset mid-operation clears everything the next cycle; the first subsequent edge is discarded again.
- Latency: a pin_in transition sampled on clk edge t produces a combinational edge in cycle t+1. FSM and outputs update on clk edge t+2, so det pulses and tone changes are visible 2 cycles after sampling.
- det pulses are exactly one cycle wide. tone is registered and glitch-free.

## Configuration
- AUDIO_DEC_STATS_EN defined:
  - Adds ports shot_count and coll_count (out, 16 bits each), reset to 0.
  - Each increments on its det pulse and saturates at 0xFFFF.
- Undefined: ports and counters are absent; all other behaviour is identical.

## Structure
- Shared package audio_pkg holds:
  - tone-code constants TONE_NONE=0, TONE_SHOT=1, TONE_COLL=2.
  - class enum SHOT/COLL/OTHER.
  - default half-period constants, shared with the generator.
- One sub-module, audio_edge_sync: synchronizer plus edge detect; outputs edge and the synced level.

## Test plan
Bench overrides: SHOT_HALF=16, COLL_HALF=128, TOL=2, CONFIRM=2, SILENCE=512.
- Toggle pin_in every 16 cycles, 6 edges → single shot_det pulse 2 cycles after the 3rd edge is sampled; tone=1, active=1, coll_det never asserted.
- Toggle every 128 cycles → single coll_det after the 3rd edge; tone=2.
- Lock shot, then switch to 128-cycle toggles → tone=0 after the first 128 edge; coll_det and tone=2 after the second.
- Half-periods of 18 → lock to shot. Half-periods of 19 or 40 → no pulses, tone stays 0.
- Stop toggling while locked → tone=0, active=0 exactly when cnt hits 512 after the last edge. An edge landing on that cycle keeps the lock.
- Assert rst for one cycle while locked → all outputs 0 next cycle. Re-lock needs 3 edges. With AUDIO_DEC_STATS_EN: 3 shot locks → shot_count=3; a count preloaded to 0xFFFF stays at 0xFFFF.
